// File: rtl/wb_arbiter_if.sv
// Register-file writeback bus: in-order pipeline results, long-latency results
// and the single registered write port.
interface wb_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              regwrite;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        output pipe_stall, lu_ready, regwrite, rd_addr, rd_data, fifo_count
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        input  pipe_stall, lu_ready, regwrite, rd_addr, rd_data, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results with buffered long-latency results
// onto one registered register-file write port, stalling the pipeline on starvation.
module wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_PIPE,
        SEL_FIFO
    } sel_e;

    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [AGE_W-1:0]  age;

    sel_e              sel;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign bus.fifo_count = count;

    // Ready and stall come from registered state only, so a same-cycle pop never frees space.
    always_comb begin
        empty          = (count == '0);
        bus.lu_ready   = (count < CNT_W'(FIFO_DEPTH));
        bus.pipe_stall = !empty && (age == AGE_W'(STARVE_LIMIT));
        push           = bus.lu_valid && bus.lu_ready;
        sel            = SEL_IDLE;
        sel_rd         = fifo_rd[head];
        sel_data       = fifo_data[head];
        if (bus.pipe_stall) begin
            sel = SEL_FIFO;
        end else if (bus.pipe_valid) begin
            sel      = SEL_PIPE;
            sel_rd   = bus.pipe_rd;
            sel_data = bus.pipe_data;
        end else if (!empty) begin
            sel = SEL_FIFO;
        end
        pop = (sel == SEL_FIFO);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= bus.lu_rd;
            fifo_data[tail] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            age          <= '0;
            bus.regwrite <= 1'b0;
            bus.rd_addr  <= '0;
            bus.rd_data  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (empty || pop)
                age <= '0;
            else if (age != AGE_W'(STARVE_LIMIT))
                age <= age + AGE_W'(1);

            if (sel == SEL_IDLE) begin
                bus.regwrite <= 1'b0;
            end else begin
                bus.regwrite <= (sel_rd != '0);
                bus.rd_addr  <= sel_rd;
                bus.rd_data  <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    ent_t              mq[$];
    int                m_age;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_stall;
    bit                m_ready;

    wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.pipe_valid === 1'b1 && bus.pipe_stall === 1'b1) begin
            n_fail++;
            $error("FAIL protocol: pipe_valid asserted during pipe_stall");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        mq.delete();
        m_age   = 0;
        m_rw    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_stall = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic set_idle();
        bus.pipe_valid = 1'b0;
        bus.pipe_rd    = '0;
        bus.pipe_data  = '0;
        bus.lu_valid   = 1'b0;
        bus.lu_rd      = '0;
        bus.lu_data    = '0;
    endtask

    // Applies one cycle of stimulus, advances the model, and returns at posedge+1.
    task automatic drive_cycle(input bit pv, input logic [ADDR_W-1:0] prd,
                               input logic [DATA_W-1:0] pdata, input bit lv,
                               input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldata,
                               output bit pushed);
        ent_t e;
        bit   popped;
        bit   pv_eff;
        int   old_size;
        pv_eff         = pv && !m_stall;
        bus.pipe_valid = pv_eff;
        bus.pipe_rd    = prd;
        bus.pipe_data  = pdata;
        bus.lu_valid   = lv;
        bus.lu_rd      = lrd;
        bus.lu_data    = ldata;
        old_size = mq.size();
        popped   = 1'b0;
        pushed   = lv && m_ready;
        if (m_stall || (!pv_eff && old_size != 0)) begin
            e      = mq.pop_front();
            popped = 1'b1;
            m_rw   = (e.rd != 0);
            m_addr = e.rd;
            m_data = e.data;
        end else if (pv_eff) begin
            m_rw   = (prd != 0);
            m_addr = prd;
            m_data = pdata;
        end else begin
            m_rw = 1'b0;
        end
        if (pushed) begin
            e.rd   = lrd;
            e.data = ldata;
            mq.push_back(e);
        end
        if (old_size == 0 || popped) m_age = 0;
        else if (m_age < STARVE_LIMIT) m_age++;
        @(posedge clk);
        #1;
        m_stall = (mq.size() != 0) && (m_age == STARVE_LIMIT);
        m_ready = (mq.size() < FIFO_DEPTH);
    endtask

    task automatic idle_cycle();
        bit p;
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, p);
    endtask

    task automatic test_reset();
        bit p;
        set_idle();
        model_reset();
        #2;
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite got %0b exp 0", bus.regwrite); end
        n_checks++; if (bus.rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_rd_addr got %0d exp 0", bus.rd_addr); end
        n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data got %h exp 0", bus.rd_data); end
        n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", bus.fifo_count); end
        n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lu_ready got %0b exp 1", bus.lu_ready); end
        n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", bus.pipe_stall); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Buffer two entries while the pipeline keeps the port busy
        drive_cycle(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd4, 32'hB0B0_0004, p);
        drive_cycle(1'b1, 5'd5, 32'hA0A0_0005, 1'b1, 5'd6, 32'hB0B0_0006, p);
        n_checks++; if (bus.fifo_count !== 2'd2) begin n_fail++; $display("FAIL midrst_precount got %0d exp 2", bus.fifo_count); end
        n_checks++; if (bus.regwrite !== 1'b1) begin n_fail++; $display("FAIL midrst_prerw got %0b exp 1", bus.regwrite); end
        set_idle();
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_regwrite got %0b exp 0", bus.regwrite); end
        n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.fifo_count); end
        n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_lu_ready got %0b exp 1", bus.lu_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL stale_write cyc %0d got rw=%0b addr=%0d exp rw=0", i, bus.regwrite, bus.rd_addr); end
        end
    endtask

    task automatic test_pipe_only();
        bit p;
        drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, p);
        n_checks++; if (bus.regwrite !== 1'b1) begin n_fail++; $display("FAIL pipe_rw got %0b exp 1", bus.regwrite); end
        n_checks++; if (bus.rd_addr !== 5'd5) begin n_fail++; $display("FAIL pipe_addr got %0d exp 5", bus.rd_addr); end
        n_checks++; if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pipe_data got %h exp deadbeef", bus.rd_data); end
        drive_cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0, p);
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL pipe_x0_rw got %0b exp 0", bus.regwrite); end
        idle_cycle();
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL pipe_idle_rw got %0b exp 0", bus.regwrite); end
    endtask

    task automatic test_lu_idle();
        bit p;
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234_5678, p);
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL lu_t1_rw got %0b exp 0", bus.regwrite); end
        n_checks++; if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL lu_t1_count got %0d exp 1", bus.fifo_count); end
        idle_cycle();
        n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd7 || bus.rd_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL lu_t2_write got rw=%0b addr=%0d data=%h exp rw=1 addr=7 data=12345678", bus.regwrite, bus.rd_addr, bus.rd_data); end
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd1, 32'h0000_1111, p);
        n_checks++; if (bus.regwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_t1_rw got %0b exp 0", bus.regwrite); end
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd2, 32'h0000_2222, p);
        n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd1 || bus.rd_data !== 32'h0000_1111) begin
            n_fail++; $display("FAIL b2b_first got rw=%0b addr=%0d data=%h exp rw=1 addr=1 data=1111", bus.regwrite, bus.rd_addr, bus.rd_data); end
        idle_cycle();
        n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd2 || bus.rd_data !== 32'h0000_2222) begin
            n_fail++; $display("FAIL b2b_second got rw=%0b addr=%0d data=%h exp rw=1 addr=2 data=2222", bus.regwrite, bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL b2b_count got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_full_fifo();
        bit   p;
        int   idx;
        int   k;
        bit   checked_full;
        logic [ADDR_W-1:0] order[$];
        idx = 0;
        checked_full = 1'b0;
        for (k = 0; k < 40 && !(idx == 3 && mq.size() == 0 && k > 3); k++) begin
            if (idx == 2 && !checked_full) begin
                checked_full = 1'b1;
                n_checks++; if (bus.lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_lu_ready got %0b exp 0", bus.lu_ready); end
            end
            n_checks++; if (bus.lu_ready !== m_ready) begin n_fail++; $display("FAIL full_ready_cyc%0d got %0b exp %0b", k, bus.lu_ready, m_ready); end
            drive_cycle(idx < 3, 5'd1, 32'h5000_0000 + k, idx < 3, 5'(10 + idx), 32'hC000_0000 + idx, p);
            if (p) idx++;
            n_checks++; if (bus.regwrite !== m_rw || bus.rd_addr !== m_addr || bus.rd_data !== m_data) begin
                n_fail++; $display("FAIL full_out_cyc%0d got rw=%0b addr=%0d data=%h exp rw=%0b addr=%0d data=%h", k, bus.regwrite, bus.rd_addr, bus.rd_data, m_rw, m_addr, m_data); end
            if (bus.regwrite === 1'b1 && bus.rd_addr >= 5'd10 && bus.rd_addr <= 5'd12) order.push_back(bus.rd_addr);
        end
        n_checks++; if (k >= 40) begin n_fail++; $display("FAIL full_bound got %0d cycles exp < 40", k); end
        n_checks++; if (order.size() != 3 || order[0] !== 5'd10 || order[1] !== 5'd11 || order[2] !== 5'd12) begin
            n_fail++; $display("FAIL full_order got %0d writes exp 10,11,12 in order", order.size()); end
    endtask

    task automatic test_starvation();
        bit p;
        drive_cycle(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd9, 32'h9999_0009, p);
        for (int k = 1; k <= 6; k++) begin
            n_checks++; if (bus.pipe_stall !== (k == 5)) begin n_fail++; $display("FAIL starve_stall_wait%0d got %0b exp %0b", k, bus.pipe_stall, (k == 5)); end
            drive_cycle(1'b1, 5'd4, 32'h4444_0000 + k, 1'b0, '0, '0, p);
            if (k == 5) begin
                n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd9 || bus.rd_data !== 32'h9999_0009) begin
                    n_fail++; $display("FAIL starve_pop got rw=%0b addr=%0d data=%h exp rw=1 addr=9 data=99990009", bus.regwrite, bus.rd_addr, bus.rd_data); end
            end else begin
                n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd4 || bus.rd_data !== 32'h4444_0000 + k) begin
                    n_fail++; $display("FAIL starve_pipe_wait%0d got rw=%0b addr=%0d data=%h exp rw=1 addr=4", k, bus.regwrite, bus.rd_addr, bus.rd_data); end
            end
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        bit p;
        drive_cycle(1'b1, 5'd3, 32'h0303_0303, 1'b1, 5'd14, 32'hAAAA_000E, p);
        n_checks++; if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL pp_count0 got %0d exp 1", bus.fifo_count); end
        n_checks++; if (bus.lu_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready got %0b exp 1", bus.lu_ready); end
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd15, 32'hBBBB_000F, p);
        n_checks++; if (bus.fifo_count !== 2'd1) begin n_fail++; $display("FAIL pp_count1 got %0d exp 1", bus.fifo_count); end
        n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd14 || bus.rd_data !== 32'hAAAA_000E) begin
            n_fail++; $display("FAIL pp_head got rw=%0b addr=%0d data=%h exp rw=1 addr=14 data=aaaa000e", bus.regwrite, bus.rd_addr, bus.rd_data); end
        idle_cycle();
        n_checks++; if (bus.regwrite !== 1'b1 || bus.rd_addr !== 5'd15 || bus.rd_data !== 32'hBBBB_000F) begin
            n_fail++; $display("FAIL pp_new got rw=%0b addr=%0d data=%h exp rw=1 addr=15 data=bbbb000f", bus.regwrite, bus.rd_addr, bus.rd_data); end
        n_checks++; if (bus.fifo_count !== 2'd0) begin n_fail++; $display("FAIL pp_count2 got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_random();
        bit p;
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            n_checks++; if (bus.pipe_stall !== m_stall || bus.lu_ready !== m_ready) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rnd_comb cyc%0d got stall=%0b ready=%0b exp stall=%0b ready=%0b", i, bus.pipe_stall, bus.lu_ready, m_stall, m_ready);
            end
            drive_cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, p);
            n_checks++; if (bus.regwrite !== m_rw || bus.rd_addr !== m_addr || bus.rd_data !== m_data || bus.fifo_count !== 2'(mq.size())) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rnd_out cyc%0d got rw=%0b addr=%0d data=%h cnt=%0d exp rw=%0b addr=%0d data=%h cnt=%0d",
                                        i, bus.regwrite, bus.rd_addr, bus.rd_data, bus.fifo_count, m_rw, m_addr, m_data, mq.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_lu_idle();
        test_full_fifo();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
